// File: rtl/multicycle_alu_if.sv
// Request/response bundle for multicycle_alu: start/ready/done handshake, operands and results.
// The overflow signal exists only when ALU_OVERFLOW_EN is defined.
interface multicycle_alu_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
);
    logic                   start;
    logic [3:0]             ALUOperation;
    logic [DATA_WIDTH-1:0]  A;
    logic [DATA_WIDTH-1:0]  B;
    logic [SHAMT_WIDTH-1:0] in_shamt;
    logic                   ready;
    logic                   done;
    logic [DATA_WIDTH-1:0]  ALUResult;
    logic                   Zero;
    logic [DATA_WIDTH-1:0]  HI;
    logic [DATA_WIDTH-1:0]  LO;
    logic                   div_by_zero;
`ifdef ALU_OVERFLOW_EN
    logic                   overflow;
`endif

    modport master (
`ifdef ALU_OVERFLOW_EN
        input  overflow,
`endif
        output start, ALUOperation, A, B, in_shamt,
        input  ready, done, ALUResult, Zero, HI, LO, div_by_zero
    );

    modport slave (
`ifdef ALU_OVERFLOW_EN
        output overflow,
`endif
        input  start, ALUOperation, A, B, in_shamt,
        output ready, done, ALUResult, Zero, HI, LO, div_by_zero
    );
endinterface

// File: rtl/multicycle_alu.sv
// EX-stage ALU: registered single-cycle ops plus iterative MULTU/DIVU into HI/LO.
// Define ALU_OVERFLOW_EN to add the signed ADD/SUB overflow flag.
module multicycle_alu #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic            clk,
    input  logic            reset,
    multicycle_alu_if.slave bus
);
    localparam logic [3:0] OP_AND   = 4'd0;
    localparam logic [3:0] OP_OR    = 4'd1;
    localparam logic [3:0] OP_NOR   = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_SLL   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_SLT   = 4'd8;
    localparam logic [3:0] OP_SLTU  = 4'd9;
    localparam logic [3:0] OP_MULTU = 4'd10;
    localparam logic [3:0] OP_DIVU  = 4'd11;
    localparam int         MSB      = DATA_WIDTH - 1;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [DATA_WIDTH-1:0]  r_a;
    logic [DATA_WIDTH-1:0]  r_b;
    logic [DATA_WIDTH-1:0]  r_wk_hi;
    logic [DATA_WIDTH-1:0]  r_wk_lo;
    logic [SHAMT_WIDTH-1:0] r_cnt;
    logic [DATA_WIDTH-1:0]  r_result;
    logic [DATA_WIDTH-1:0]  r_hi;
    logic [DATA_WIDTH-1:0]  r_lo;
    logic                   r_zero;
    logic                   r_dbz;

    logic                   w_ready;
    logic                   w_accept;
    logic                   w_last;
    logic [DATA_WIDTH-1:0]  w_alu;
    logic [DATA_WIDTH:0]    w_mul_sum;
    logic [DATA_WIDTH:0]    w_div_shift;
    logic [DATA_WIDTH:0]    w_div_diff;
    logic [DATA_WIDTH-1:0]  w_step_hi;
    logic [DATA_WIDTH-1:0]  w_step_lo;

    assign w_ready  = (r_state == IDLE) || (r_state == DONE);
    assign w_accept = bus.start && w_ready;
    assign w_last   = (r_cnt == SHAMT_WIDTH'(DATA_WIDTH - 1));

    always_comb begin
        w_alu = '0;
        case (bus.ALUOperation)
            OP_AND:  w_alu = bus.A & bus.B;
            OP_OR:   w_alu = bus.A | bus.B;
            OP_NOR:  w_alu = ~(bus.A | bus.B);
            OP_ADD:  w_alu = bus.A + bus.B;
            OP_SUB:  w_alu = bus.A - bus.B;
            OP_SLL:  w_alu = bus.B << bus.in_shamt;
            OP_SRL:  w_alu = bus.B >> bus.in_shamt;
            OP_SRA:  w_alu = $signed(bus.B) >>> bus.in_shamt;
            OP_SLT:  w_alu = {{(DATA_WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
            OP_SLTU: w_alu = {{(DATA_WIDTH-1){1'b0}}, (bus.A < bus.B)};
            default: w_alu = '0;
        endcase
    end

`ifdef ALU_OVERFLOW_EN
    logic w_alu_ovf;
    logic r_ovf;

    always_comb begin
        w_alu_ovf = 1'b0;
        if (bus.ALUOperation == OP_ADD)
            w_alu_ovf = (bus.A[MSB] == bus.B[MSB]) && (w_alu[MSB] != bus.A[MSB]);
        else if (bus.ALUOperation == OP_SUB)
            w_alu_ovf = (bus.A[MSB] != bus.B[MSB]) && (w_alu[MSB] != bus.A[MSB]);
    end

    assign bus.overflow = r_ovf;
`endif

    // MUL: {hi,lo} holds {partial sum, remaining multiplier}; DIV: {remainder, dividend->quotient}.
    assign w_mul_sum   = {1'b0, r_wk_hi} + (r_wk_lo[0] ? {1'b0, r_a} : {(DATA_WIDTH+1){1'b0}});
    assign w_div_shift = {r_wk_hi, r_wk_lo[MSB]};
    assign w_div_diff  = w_div_shift - {1'b0, r_b};

    always_comb begin
        w_step_hi = w_mul_sum[DATA_WIDTH:1];
        w_step_lo = {w_mul_sum[0], r_wk_lo[MSB:1]};
        if (r_state == DIV) begin
            w_step_hi = w_div_diff[DATA_WIDTH] ? w_div_shift[MSB:0] : w_div_diff[MSB:0];
            w_step_lo = {r_wk_lo[MSB-1:0], ~w_div_diff[DATA_WIDTH]};
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (r_state == DONE)
                    w_state_next = IDLE;
                if (bus.start) begin
                    case (bus.ALUOperation)
                        OP_MULTU: w_state_next = MUL;
                        OP_DIVU:  w_state_next = DIV;
                        default:  w_state_next = DONE;
                    endcase
                end
            end
            MUL, DIV: begin
                if (w_last)
                    w_state_next = DONE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_wk_hi  <= '0;
            r_wk_lo  <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_zero   <= 1'b0;
            r_dbz    <= 1'b0;
`ifdef ALU_OVERFLOW_EN
            r_ovf    <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_a     <= bus.A;
                r_b     <= bus.B;
                r_cnt   <= '0;
                r_wk_hi <= '0;
                if (bus.ALUOperation == OP_MULTU) begin
                    r_wk_lo <= bus.B;
                end else if (bus.ALUOperation == OP_DIVU) begin
                    r_wk_lo <= bus.A;
                end else begin
                    r_result <= w_alu;
                    r_zero   <= (w_alu == '0);
                    r_dbz    <= 1'b0;
`ifdef ALU_OVERFLOW_EN
                    r_ovf    <= w_alu_ovf;
`endif
                end
            end else if ((r_state == MUL) || (r_state == DIV)) begin
                r_wk_hi <= w_step_hi;
                r_wk_lo <= w_step_lo;
                r_cnt   <= r_cnt + 1'b1;
                if (w_last) begin
`ifdef ALU_OVERFLOW_EN
                    r_ovf <= 1'b0;
`endif
                    // Divide-by-zero result is defined explicitly rather than left to the datapath.
                    if ((r_state == DIV) && (r_b == '0)) begin
                        r_hi     <= r_a;
                        r_lo     <= '1;
                        r_result <= '1;
                        r_zero   <= 1'b0;
                        r_dbz    <= 1'b1;
                    end else begin
                        r_hi     <= w_step_hi;
                        r_lo     <= w_step_lo;
                        r_result <= w_step_lo;
                        r_zero   <= (w_step_lo == '0);
                        r_dbz    <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.ready       = w_ready;
    assign bus.done        = (r_state == DONE);
    assign bus.ALUResult   = r_result;
    assign bus.Zero        = r_zero;
    assign bus.HI          = r_hi;
    assign bus.LO          = r_lo;
    assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu: directed scenarios plus randomized ops against a reference model.
module tb_multicycle_alu;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_alu_if #(.DATA_WIDTH(32)) bus();
    multicycle_alu #(.DATA_WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_vec = 0;
    int n_err = 0;
    int lat;
    int busy;
    logic [31:0] m_res, m_hi, m_lo;
    bit m_dbz, m_ovf;
    int m_lat;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
        bus.start = 1'b1;
        bus.ALUOperation = op;
        bus.A = a;
        bus.B = b;
        bus.in_shamt = sh;
    endtask

    // Issue one op and wait (bounded) for its done pulse; lat = cycles from accept to done.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
        drive(op, a, b, sh);
        tick();
        bus.start = 1'b0;
        lat = 1;
        busy = 0;
        while (bus.done !== 1'b1 && lat < 100) begin
            if (bus.ready === 1'b0) busy++;
            tick();
            lat++;
        end
    endtask

    // Reference model from the opcode table; HI/LO persist across single-cycle ops.
    task automatic model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
        logic [63:0] p;
        m_dbz = 1'b0;
        m_ovf = 1'b0;
        m_lat = 1;
        case (op)
            4'd0:  m_res = a & b;
            4'd1:  m_res = a | b;
            4'd2:  m_res = ~(a | b);
            4'd3:  begin m_res = a + b; m_ovf = (a[31] == b[31]) && (m_res[31] != a[31]); end
            4'd4:  begin m_res = a - b; m_ovf = (a[31] != b[31]) && (m_res[31] != a[31]); end
            4'd5:  m_res = b << sh;
            4'd6:  m_res = b >> sh;
            4'd7:  m_res = $signed(b) >>> sh;
            4'd8:  m_res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:  m_res = (a < b) ? 32'd1 : 32'd0;
            4'd10: begin
                p = {32'd0, a} * {32'd0, b};
                m_hi = p[63:32]; m_lo = p[31:0]; m_res = m_lo; m_lat = 33;
            end
            4'd11: begin
                if (b == 0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; m_dbz = 1'b1; end
                else begin m_lo = a / b; m_hi = a % b; end
                m_res = m_lo; m_lat = 33;
            end
            default: m_res = 32'd0;
        endcase
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.ALUOperation = 4'd0; bus.A = '0; bus.B = '0; bus.in_shamt = '0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        m_hi = 0; m_lo = 0;
        n_vec++;
        if ({bus.ready, bus.done, bus.Zero, bus.div_by_zero} !== 4'b1000) begin
            n_err++; $display("FAIL reset_flags: got %b expected 1000", {bus.ready, bus.done, bus.Zero, bus.div_by_zero});
        end
        n_vec++;
        if ({bus.ALUResult, bus.HI, bus.LO} !== 96'd0) begin
            n_err++; $display("FAIL reset_data: got %h expected 0", {bus.ALUResult, bus.HI, bus.LO});
        end
`ifdef ALU_OVERFLOW_EN
        n_vec++;
        if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b expected 0", bus.overflow); end
`endif
        $display("reset: ready=%b done=%b", bus.ready, bus.done);
    endtask

    task automatic test_add_wrap();
        run_op(4'd3, 32'hFFFF_FFFF, 32'd1, 5'd0);
        n_vec++;
        if (lat !== 1) begin n_err++; $display("FAIL add_latency: got %0d expected 1", lat); end
        n_vec++;
        if ({bus.ALUResult, bus.Zero, bus.HI, bus.LO} !== {32'd0, 1'b1, 64'd0}) begin
            n_err++; $display("FAIL add_wrap: got res=%h zero=%b hi=%h lo=%h expected 0 1 0 0", bus.ALUResult, bus.Zero, bus.HI, bus.LO);
        end
`ifdef ALU_OVERFLOW_EN
        n_vec++;
        if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL add_ovf: got %b expected 0", bus.overflow); end
`endif
        $display("ADD ffffffff+1: res=%h zero=%b lat=%0d", bus.ALUResult, bus.Zero, lat);
    endtask

    task automatic test_back_to_back();
        drive(4'd7, 32'd0, 32'h8000_0000, 5'd4);
        tick();
        n_vec++;
        if ({bus.done, bus.ALUResult} !== {1'b1, 32'hF800_0000}) begin
            n_err++; $display("FAIL b2b_sra: got done=%b res=%h expected 1 f8000000", bus.done, bus.ALUResult);
        end
        $display("SRA 80000000>>>4: res=%h", bus.ALUResult);
        drive(4'd8, 32'hFFFF_FFFF, 32'd1, 5'd0);
        tick();
        bus.start = 1'b0;
        n_vec++;
        if ({bus.done, bus.ALUResult} !== {1'b1, 32'd1}) begin
            n_err++; $display("FAIL b2b_slt: got done=%b res=%h expected 1 00000001", bus.done, bus.ALUResult);
        end
        $display("SLT -1<1 back-to-back: res=%h", bus.ALUResult);
        tick();
        n_vec++;
        if ({bus.done, bus.ready} !== 2'b01) begin
            n_err++; $display("FAIL b2b_idle: got done/ready=%b expected 01", {bus.done, bus.ready});
        end
    endtask

    task automatic test_multu();
        run_op(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
        m_hi = 32'hFFFF_FFFE; m_lo = 32'd1;
        n_vec++;
        if (lat !== 33 || busy !== 32) begin
            n_err++; $display("FAIL multu_timing: got lat=%0d busy=%0d expected 33 32", lat, busy);
        end
        n_vec++;
        if ({bus.HI, bus.LO, bus.ALUResult} !== {32'hFFFF_FFFE, 32'd1, 32'd1}) begin
            n_err++; $display("FAIL multu_max: got hi=%h lo=%h res=%h expected fffffffe 1 1", bus.HI, bus.LO, bus.ALUResult);
        end
        $display("MULTU ffffffff*ffffffff: hi=%h lo=%h lat=%0d", bus.HI, bus.LO, lat);
    endtask

    task automatic test_divu();
        run_op(4'd11, 32'd100, 32'd7, 5'd0);
        n_vec++;
        if ({bus.LO, bus.HI, bus.div_by_zero} !== {32'd14, 32'd2, 1'b0} || lat !== 33) begin
            n_err++; $display("FAIL divu_100_7: got lo=%0d hi=%0d dbz=%b lat=%0d expected 14 2 0 33", bus.LO, bus.HI, bus.div_by_zero, lat);
        end
        $display("DIVU 100/7: lo=%0d hi=%0d", bus.LO, bus.HI);
        run_op(4'd11, 32'd5, 32'd0, 5'd0);
        m_hi = 32'd5; m_lo = 32'hFFFF_FFFF;
        n_vec++;
        if ({bus.LO, bus.HI, bus.ALUResult, bus.div_by_zero} !== {32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 1'b1} || lat !== 33) begin
            n_err++; $display("FAIL divu_by_zero: got lo=%h hi=%h dbz=%b lat=%0d expected ffffffff 5 1 33", bus.LO, bus.HI, bus.div_by_zero, lat);
        end
        $display("DIVU 5/0: lo=%h hi=%h dbz=%b", bus.LO, bus.HI, bus.div_by_zero);
    endtask

    task automatic test_busy_ignore();
        logic [31:0] a, b;
        a = $urandom; b = $urandom;
        model_op(4'd10, a, b, 5'd0);
        drive(4'd10, a, b, 5'd0);
        tick();
        bus.start = 1'b0;
        lat = 1;
        while (bus.done !== 1'b1 && lat < 100) begin
            if (lat == 3) drive(4'd3, ~a, b + 32'd1, 5'd3);
            if (lat == 5) begin bus.start = 1'b0; bus.A = $urandom; bus.B = $urandom; end
            tick();
            lat++;
        end
        n_vec++;
        if (lat !== 33 || {bus.HI, bus.LO} !== {m_hi, m_lo}) begin
            n_err++; $display("FAIL busy_ignore: got lat=%0d hi=%h lo=%h expected 33 %h %h", lat, bus.HI, bus.LO, m_hi, m_lo);
        end
        $display("MULTU %h*%h with start during busy: hi=%h lo=%h", a, b, bus.HI, bus.LO);
        tick();
        n_vec++;
        if ({bus.done, bus.ready} !== 2'b01) begin
            n_err++; $display("FAIL busy_no_extra_done: got done/ready=%b expected 01", {bus.done, bus.ready});
        end
    endtask

    task automatic test_reset_mid_div();
        logic [31:0] a, b;
        bit seen;
        a = $urandom; b = $urandom_range(1, 1000);
        drive(4'd11, a, b, 5'd0);
        tick();
        bus.start = 1'b0;
        seen = 1'b0;
        repeat (9) begin
            tick();
            if (bus.done === 1'b1) seen = 1'b1;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_hi = 0; m_lo = 0;
        n_vec++;
        if ({seen, bus.done, bus.ready, bus.Zero, bus.div_by_zero} !== 5'b00100 || {bus.ALUResult, bus.HI, bus.LO} !== 96'd0) begin
            n_err++; $display("FAIL reset_mid_div: got seen=%b done=%b ready=%b data=%h expected 0 0 1 0", seen, bus.done, bus.ready, {bus.ALUResult, bus.HI, bus.LO});
        end
        $display("DIVU aborted by reset: ready=%b done=%b", bus.ready, bus.done);
        run_op(4'd0, a, 32'hF0F0_F0F0, 5'd0);
        n_vec++;
        if (lat !== 1 || {bus.ALUResult, bus.HI, bus.LO} !== {a & 32'hF0F0_F0F0, 64'd0}) begin
            n_err++; $display("FAIL and_after_reset: got lat=%0d res=%h hi=%h lo=%h expected 1 %h 0 0", lat, bus.ALUResult, bus.HI, bus.LO, a & 32'hF0F0_F0F0);
        end
        $display("AND after reset: res=%h", bus.ALUResult);
    endtask

    task automatic test_random();
        logic [3:0] op;
        logic [31:0] a, b;
        logic [4:0] sh;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = a;
            sh = 5'($urandom);
            model_op(op, a, b, sh);
            run_op(op, a, b, sh);
            n_vec++;
            if (lat !== m_lat || busy !== m_lat - 1) begin
                n_err++; $display("FAIL rand_timing op=%0d: got lat=%0d busy=%0d expected %0d %0d", op, lat, busy, m_lat, m_lat - 1);
            end
            n_vec++;
            if ({bus.ALUResult, bus.Zero, bus.div_by_zero} !== {m_res, (m_res == 0), m_dbz}) begin
                n_err++; $display("FAIL rand_result op=%0d a=%h b=%h sh=%0d: got %h z=%b dbz=%b expected %h z=%b dbz=%b",
                                  op, a, b, sh, bus.ALUResult, bus.Zero, bus.div_by_zero, m_res, (m_res == 0), m_dbz);
            end
            n_vec++;
            if ({bus.HI, bus.LO} !== {m_hi, m_lo}) begin
                n_err++; $display("FAIL rand_hilo op=%0d: got %h %h expected %h %h", op, bus.HI, bus.LO, m_hi, m_lo);
            end
`ifdef ALU_OVERFLOW_EN
            n_vec++;
            if (bus.overflow !== m_ovf) begin
                n_err++; $display("FAIL rand_ovf op=%0d a=%h b=%h: got %b expected %b", op, a, b, bus.overflow, m_ovf);
            end
`endif
            $display("op=%0d a=%h b=%h sh=%0d -> res=%h hi=%h lo=%h lat=%0d", op, a, b, sh, bus.ALUResult, bus.HI, bus.LO, lat);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        test_reset();
        test_add_wrap();
        test_back_to_back();
        test_multu();
        test_divu();
        test_busy_ignore();
        test_reset_mid_div();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
